// File: rtl/bpu_pkg.sv
// Shared constants for the fetch-stage branch predictor: opcodes, BHT counter
// encoding and the link registers used for return-address-stack hints.
package bpu_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_SNT = 2'b00;
  localparam bht_cnt_t CNT_WNT = 2'b01;
  localparam bht_cnt_t CNT_WT  = 2'b10;
  localparam bht_cnt_t CNT_ST  = 2'b11;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack: a pop followed by a push in one cycle replaces the top;
// pushing when full overwrites the oldest entry while the count saturates at DEPTH.
module bpu_ras #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, wr_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_pop;
  logic             do_pop;
  logic [PC_W-1:0]  stack_q [DEPTH];

  // ptr_q addresses the next free slot; the top lives one below it.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    wr_ptr  = do_pop ? ptr_q - PTR_W'(1) : ptr_q;
    cnt_pop = do_pop ? cnt_q - CNT_W'(1) : cnt_q;
    ptr_d   = wr_ptr;
    cnt_d   = cnt_pop;
    if (push_i) begin
      ptr_d = wr_ptr + PTR_W'(1);
      cnt_d = (cnt_pop == CNT_W'(DEPTH)) ? cnt_pop : cnt_pop + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) stack_q[wr_ptr] <= push_data_i;
  end

  assign top_o   = stack_q[ptr_q - PTR_W'(1)];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bpu_bht.sv
// Fetch-stage predictor: 2-bit counter BHT for branches, JAL always taken.
// Define BPU_RAS_EN to add a return-address stack that predicts JALR returns.
module bpu_bht
  import bpu_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            fetch_fire_i,
  input  logic [31:0]     inst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_pc_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  bht_cnt_t         bht_q [BHT_DEPTH];
  bht_cnt_t         bht_d [BHT_DEPTH];
  logic [IDX_W-1:0] lookup_idx, upd_idx;
  logic [6:0]       opcode;
  logic [PC_W-1:0]  imm_b, imm_j, pc_plus4;

  assign opcode     = inst_i[6:0];
  assign lookup_idx = pc_i[IDX_W+1:2];
  assign upd_idx    = upd_pc_i[IDX_W+1:2];
  assign imm_b      = {{(PC_W-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j      = {{(PC_W-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign pc_plus4   = pc_i + PC_W'(4);

  always_comb begin
    bht_d = bht_q;
    if (upd_valid_i) begin
      if (upd_taken_i)
        bht_d[upd_idx] = (bht_q[upd_idx] == CNT_ST) ? CNT_ST : bht_q[upd_idx] + 2'd1;
      else
        bht_d[upd_idx] = (bht_q[upd_idx] == CNT_SNT) ? CNT_SNT : bht_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_WNT;
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BPU_RAS_EN
  logic [4:0]      rd, rs1;
  logic            rd_link, rs1_link, is_ret, ras_push, ras_pop, ras_empty;
  logic [PC_W-1:0] ras_top;

  assign rd       = inst_i[11:7];
  assign rs1      = inst_i[19:15];
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);
  // rd == rs1 with both links is a call through the link register, not a return.
  assign is_ret   = (opcode == OPC_JALR) && rs1_link && !(rd_link && (rd == rs1));
  assign ras_push = fetch_fire_i && ((opcode == OPC_JAL) || (opcode == OPC_JALR)) && rd_link;
  assign ras_pop  = fetch_fire_i && is_ret;

  bpu_ras #(
    .DEPTH (RAS_DEPTH),
    .PC_W  (PC_W)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_fetch_fire;
  assign unused_fetch_fire = fetch_fire_i;
`endif

  always_comb begin
    pred_taken_o = 1'b0;
    pred_pc_o    = pc_plus4;
    case (opcode)
      OPC_BRANCH: begin
        if (bht_q[lookup_idx][1]) begin
          pred_taken_o = 1'b1;
          pred_pc_o    = pc_i + imm_b;
        end
      end
      OPC_JAL: begin
        pred_taken_o = 1'b1;
        pred_pc_o    = pc_i + imm_j;
      end
`ifdef BPU_RAS_EN
      OPC_JALR: begin
        if (is_ret && !ras_empty) begin
          pred_taken_o = 1'b1;
          pred_pc_o    = ras_top;
        end
      end
`endif
      default: ;
    endcase
  end

  logic unused_upd_pc;
  assign unused_upd_pc = ^{upd_pc_i[1:0], upd_pc_i[PC_W-1:IDX_W+2]};

endmodule

// File: tb/tb_bpu_bht.sv
// Directed self-checking bench for bpu_bht: BHT training, saturation, aliasing,
// update/lookup ordering, JAL wrap, async reset and (with BPU_RAS_EN) the RAS.
module tb_bpu_bht;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_fire = 1'b0;
  logic [31:0] inst = 32'h0000_0013;
  logic [31:0] pc = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  bpu_bht #(.PC_W(32), .BHT_DEPTH(64), .RAS_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .fetch_fire_i (fetch_fire),
    .inst_i       (inst),
    .pc_i         (pc),
    .pred_taken_o (pred_taken),
    .pred_pc_o    (pred_pc),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_taken_i  (upd_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] i, input logic [31:0] p);
    inst = i;
    pc   = p;
    #1;
  endtask

  task automatic train(input logic [31:0] p, input logic t, input int n);
    for (int k = 0; k < n; k++) begin
      upd_valid = 1'b1;
      upd_pc    = p;
      upd_taken = t;
      tick();
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch(enc_b(13'd16), 32'h8000_0000);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL reset_branch: taken=%0b pc=%h, expected taken=0 pc=80000004", pred_taken, pred_pc);
    end
    tick();
    tick();
    rst_n = 1'b1;
    fetch(32'h0000_0013, 32'h1000_0000);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h1000_0004) begin
      n_fail++;
      $display("FAIL other_opcode: taken=%0b pc=%h, expected taken=0 pc=10000004", pred_taken, pred_pc);
    end
    $display("test_reset done");
  endtask

  task automatic test_train();
    train(32'h8000_0000, 1'b1, 2);
    fetch(enc_b(13'd16), 32'h8000_0000);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL train_taken: taken=%0b pc=%h, expected taken=1 pc=80000010", pred_taken, pred_pc);
    end
    train(32'h8000_0000, 1'b1, 4);
    train(32'h8000_0000, 1'b0, 1);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL saturate_high: taken=%0b pc=%h, expected taken=1 pc=80000010", pred_taken, pred_pc);
    end
    train(32'h8000_0000, 1'b0, 1);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL train_not_taken: taken=%0b pc=%h, expected taken=0 pc=80000004", pred_taken, pred_pc);
    end
    $display("test_train done");
  endtask

  task automatic test_same_cycle();
    fetch(enc_b(13'd16), 32'h8000_0000);
    upd_valid = 1'b1;
    upd_pc    = 32'h8000_0000;
    upd_taken = 1'b1;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_old: taken=%0b, expected 0", pred_taken);
    end
    tick();
    upd_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL same_cycle_new: taken=%0b pc=%h, expected taken=1 pc=80000010", pred_taken, pred_pc);
    end
    $display("test_same_cycle done");
  endtask

  task automatic test_alias();
    // Index 0 is WT here; 0x8000_0100 shares it.
    fetch(enc_b(13'd32), 32'h8000_0100);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0120) begin
      n_fail++;
      $display("FAIL alias_read: taken=%0b pc=%h, expected taken=1 pc=80000120", pred_taken, pred_pc);
    end
    train(32'h8000_0100, 1'b0, 1);
    fetch(enc_b(13'd16), 32'h8000_0000);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL alias_flip: taken=%0b pc=%h, expected taken=0 pc=80000004", pred_taken, pred_pc);
    end
    train(32'h8000_0008, 1'b1, 1);
    fetch(enc_b(13'h1FF8), 32'h8000_0008);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL neg_imm_b: taken=%0b pc=%h, expected taken=1 pc=80000000", pred_taken, pred_pc);
    end
    fetch(enc_b(13'd16), 32'h8000_0000);
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL index_isolation: taken=%0b, expected 0", pred_taken);
    end
    $display("test_alias done");
  endtask

  task automatic test_jal();
    fetch(enc_j(21'h20, 5'd0), 32'hFFFF_FFF0);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL jal_wrap: taken=%0b pc=%h, expected taken=1 pc=00000010", pred_taken, pred_pc);
    end
    fetch(enc_j(21'h1FF000, 5'd0), 32'h0000_2000);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL jal_neg: taken=%0b pc=%h, expected taken=1 pc=00001000", pred_taken, pred_pc);
    end
    $display("test_jal done");
  endtask

  task automatic test_jalr();
    logic [31:0] exp_pc [5];
`ifdef BPU_RAS_EN
    exp_pc = '{32'h144, 32'h134, 32'h124, 32'h114, 32'h0};
    fetch_fire = 1'b1;
    for (int k = 0; k < 5; k++) begin
      fetch(enc_j(21'h40, 5'd1), 32'h100 + 32'(k) * 32'h10);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      fetch(enc_jalr(5'd0, 5'd1), 32'h400);
      n_checks++;
      if (k < 4 && (pred_taken !== 1'b1 || pred_pc !== exp_pc[k])) begin
        n_fail++;
        $display("FAIL ras_ret%0d: taken=%0b pc=%h, expected taken=1 pc=%h", k, pred_taken, pred_pc, exp_pc[k]);
      end else if (k == 4 && (pred_taken !== 1'b0 || pred_pc !== 32'h404)) begin
        n_fail++;
        $display("FAIL ras_empty: taken=%0b pc=%h, expected taken=0 pc=00000404", pred_taken, pred_pc);
      end
      tick();
    end
    fetch(enc_j(21'h40, 5'd5), 32'h300);
    tick();
    fetch_fire = 1'b0;
    fetch(enc_jalr(5'd0, 5'd1), 32'h400);
    tick();
    fetch_fire = 1'b1;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h304) begin
      n_fail++;
      $display("FAIL ras_no_fire: taken=%0b pc=%h, expected taken=1 pc=00000304", pred_taken, pred_pc);
    end
    tick();
    fetch_fire = 1'b0;
`else
    exp_pc = '{32'h404, 32'h0, 32'h0, 32'h0, 32'h0};
    fetch(enc_jalr(5'd0, 5'd1), 32'h400);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_pc !== exp_pc[0]) begin
      n_fail++;
      $display("FAIL jalr_no_ras: taken=%0b pc=%h, expected taken=0 pc=%h", pred_taken, pred_pc, exp_pc[0]);
    end
`endif
    $display("test_jalr done");
  endtask

  task automatic test_reset_mid();
    train(32'h8000_000C, 1'b1, 2);
    fetch(enc_b(13'd16), 32'h8000_000C);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_pc !== 32'h8000_001C) begin
      n_fail++;
      $display("FAIL pre_reset: taken=%0b pc=%h, expected taken=1 pc=8000001c", pred_taken, pred_pc);
    end
    upd_valid = 1'b1;
    upd_pc    = 32'h8000_000C;
    upd_taken = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_pc !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL async_reset: taken=%0b pc=%h, expected taken=0 pc=80000010", pred_taken, pred_pc);
    end
    tick();
    upd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_dropped: taken=%0b, expected 0", pred_taken);
    end
    train(32'h8000_000C, 1'b1, 1);
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_is_wnt: taken=%0b, expected 1", pred_taken);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    #2;
    test_reset();
    test_train();
    test_same_cycle();
    test_alias();
    test_jal();
    test_jalr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
